axi4lite_master: RTL and testbench

AXI4LITE_MASTER -- requirements
Module: axi4lite_master

---
 rtl/axi4lite_master.sv | 137 +++++++++++++
 tb/tb_axi4lite_master.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master.sv
// axi4lite_master: single-outstanding AXI4-Lite master behind a simple request/ready bus.
// Define AXI4LITE_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module axi4lite_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bus_req,
    input  logic                    bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic [DATA_WIDTH-1:0]   bus_wr_data,
    input  logic [DATA_WIDTH/8-1:0] bus_wr_strobe,
    output logic                    bus_ready,
    output logic [DATA_WIDTH-1:0]   bus_rd_data,
    output logic                    bus_err,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;
    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                    err_q, err_d;
    logic                    timeout;
    logic                    unused_resp;
    assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = (state_q == IDLE) ? '0 : (state_q == DONE) ? cnt_q : cnt_q + 1'b1;
    assign timeout = state_q != IDLE && state_q != DONE && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        arvalid_d = arvalid_q & ~M_AXI_ARREADY;
        case (state_q)
            IDLE: if (bus_req) begin
                addr_d    = bus_addr;
                wdata_d   = bus_wr_data;
                wstrb_d   = bus_wr_strobe;
                awvalid_d = bus_req_is_wr;
                wvalid_d  = bus_req_is_wr;
                arvalid_d = ~bus_req_is_wr;
                state_d   = bus_req_is_wr ? WR_REQ : RD_REQ;
            end
            // Move on only once the VALIDs have actually dropped, keeping read and write latency equal.
            WR_REQ:  if (!awvalid_q && !wvalid_q) state_d = WR_RESP;
            RD_REQ:  if (!arvalid_q) state_d = RD_RESP;
            WR_RESP: if (M_AXI_BVALID) begin
                err_d   = M_AXI_BRESP[1];
                rdata_d = '0;
                state_d = DONE;
            end
            RD_RESP: if (M_AXI_RVALID) begin
                err_d   = M_AXI_RRESP[1];
                rdata_d = M_AXI_RDATA;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            err_d     = 1'b1;
            rdata_d   = '0;
            state_d   = DONE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
        end
    end
    assign bus_ready     = state_q == DONE;
    assign bus_err       = bus_ready & err_q;
    assign bus_rd_data   = rdata_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_BREADY  = state_q == WR_RESP;
    assign M_AXI_RREADY  = state_q == RD_RESP;
endmodule

// File: tb/tb_axi4lite_master.sv
// tb_axi4lite_master: directed tests of axi4lite_master; cycle 0 is the cycle the request is driven.
module tb_axi4lite_master;
    logic        clk = 0, reset = 1;
    logic        bus_req = 0, bus_req_is_wr = 0;
    logic [31:0] bus_addr = 0, bus_wr_data = 0;
    logic [3:0]  bus_wr_strobe = 0;
    logic        bus_ready, bus_err;
    logic [31:0] bus_rd_data;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;
    int checks = 0, errors = 0;
    int cyc, first_rdy, last_rdy, n_rdy;
    logic [31:0] rdy_data;
    logic        rdy_err;

    axi4lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_strobe(bus_wr_strobe),
        .bus_ready(bus_ready), .bus_rd_data(bus_rd_data), .bus_err(bus_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (bus_ready) begin
            if (n_rdy == 0) begin
                first_rdy = cyc;
                rdy_data  = bus_rd_data;
                rdy_err   = bus_err;
            end
            last_rdy = cyc;
            n_rdy++;
        end
    endtask

    task automatic slave(input logic aw, input logic w, input logic b, input logic ar, input logic r);
        awready = aw; wready = w; bvalid = b; arready = ar; rvalid = r;
    endtask

    task automatic clear_log;
        cyc = 0; n_rdy = 0; first_rdy = -1; last_rdy = -1;
    endtask

    task automatic start(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_req_is_wr = wr; bus_addr = a; bus_wr_data = d; bus_wr_strobe = s;
        bus_req = 1;
        clear_log();
        tick();
        bus_req = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        clear_log();
        repeat (2) tick();
        reset = 0;
        checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus_ready); end
        checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin errors++; $display("FAIL reset_handshake got %b want 00000", {awvalid, wvalid, arvalid, bready, rready}); end
        checks++; if ({awaddr, wdata, wstrb} !== 68'h0) begin errors++; $display("FAIL reset_axi_payload got %h want 0", {awaddr, wdata, wstrb}); end
        checks++; if ({bus_rd_data, bus_err} !== 33'h0) begin errors++; $display("FAIL reset_bus_out got %h want 0", {bus_rd_data, bus_err}); end
    endtask

    task automatic test_write_zero_wait;
        slave(1, 1, 1, 0, 0); bresp = 2'b00;
        start(1, 32'h10, 32'hDEADBEEF, 4'hF);
        checks++; if ({awvalid, wvalid, arvalid} !== 3'b110) begin errors++; $display("FAIL wr_valids_c1 got %b want 110", {awvalid, wvalid, arvalid}); end
        checks++; if (awaddr !== 32'h10) begin errors++; $display("FAIL wr_awaddr got %h want 00000010", awaddr); end
        checks++; if (wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin errors++; $display("FAIL wr_wdata got %h/%h want deadbeef/f", wdata, wstrb); end
        repeat (8) tick();
        checks++; if (first_rdy !== 4) begin errors++; $display("FAIL wr_latency got %0d want 4", first_rdy); end
        checks++; if (n_rdy !== 1) begin errors++; $display("FAIL wr_pulses got %0d want 1", n_rdy); end
        checks++; if (rdy_err !== 1'b0 || rdy_data !== 32'h0) begin errors++; $display("FAIL wr_result got err=%b data=%h want err=0 data=0", rdy_err, rdy_data); end
    endtask

    task automatic test_read_slverr;
        slave(0, 0, 0, 1, 1); rdata = 32'h12345678; rresp = 2'b10;
        start(0, 32'h20, 32'h0, 4'h0);
        checks++; if ({awvalid, wvalid, arvalid} !== 3'b001 || araddr !== 32'h20) begin errors++; $display("FAIL rd_ar_c1 got v=%b a=%h want v=001 a=00000020", {awvalid, wvalid, arvalid}, araddr); end
        repeat (8) tick();
        checks++; if (first_rdy !== 4 || n_rdy !== 1) begin errors++; $display("FAIL rd_ready got cyc=%0d n=%0d want cyc=4 n=1", first_rdy, n_rdy); end
        checks++; if (rdy_data !== 32'h12345678) begin errors++; $display("FAIL rd_data got %h want 12345678", rdy_data); end
        checks++; if (rdy_err !== 1'b1) begin errors++; $display("FAIL rd_slverr got %b want 1", rdy_err); end
        rdata = 32'hFFFF0000; rvalid = 0;
        repeat (3) tick();
        checks++; if (bus_rd_data !== 32'h12345678) begin errors++; $display("FAIL rd_data_hold got %h want 12345678", bus_rd_data); end
    endtask

    task automatic test_write_late_wready;
        int aw_bad = 0, w_bad = 0;
        slave(1, 0, 1, 0, 0); bresp = 2'b01;
        start(1, 32'h44, 32'hA5A55A5A, 4'h3);
        for (int i = 0; i < 12; i++) begin
            wready = (cyc >= 4);
            if (cyc >= 2 && awvalid) aw_bad++;
            if (cyc >= 2 && cyc <= 4 && (!wvalid || wdata !== 32'hA5A55A5A || wstrb !== 4'h3)) w_bad++;
            if (cyc >= 5 && wvalid) w_bad++;
            tick();
        end
        checks++; if (aw_bad !== 0) begin errors++; $display("FAIL late_awvalid_drop got %0d bad cycles want 0", aw_bad); end
        checks++; if (w_bad !== 0) begin errors++; $display("FAIL late_wvalid_hold got %0d bad cycles want 0", w_bad); end
        checks++; if (first_rdy !== 7 || n_rdy !== 1) begin errors++; $display("FAIL late_ready got cyc=%0d n=%0d want cyc=7 n=1", first_rdy, n_rdy); end
        checks++; if (rdy_err !== 1'b0 || rdy_data !== 32'h0) begin errors++; $display("FAIL late_exokay got err=%b data=%h want err=0 data=0", rdy_err, rdy_data); end
    endtask

    task automatic test_back_to_back;
        int n_ar = 0, overlap = 0;
        logic [31:0] ar_a [2];
        ar_a[0] = 0; ar_a[1] = 0;
        slave(0, 0, 0, 1, 1); rdata = 32'hCAFEF00D; rresp = 2'b00;
        bus_req_is_wr = 0; bus_addr = 32'h30; bus_req = 1;
        clear_log();
        for (int i = 0; i < 15; i++) begin
            if (cyc == 3) bus_addr = 32'h34;
            if (cyc == 10) bus_req = 0;
            if (arvalid && arready) begin
                if (n_ar < 2) ar_a[n_ar] = araddr;
                n_ar++;
            end
            if ((arvalid || awvalid) && bus_ready) overlap++;
            tick();
        end
        checks++; if (n_rdy !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", n_rdy); end
        checks++; if (first_rdy !== 4 || last_rdy !== 9) begin errors++; $display("FAIL b2b_timing got %0d,%0d want 4,9", first_rdy, last_rdy); end
        checks++; if (n_ar !== 2) begin errors++; $display("FAIL b2b_ar_count got %0d want 2", n_ar); end
        checks++; if (ar_a[0] !== 32'h30 || ar_a[1] !== 32'h34) begin errors++; $display("FAIL b2b_araddr got %h,%h want 30,34", ar_a[0], ar_a[1]); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap got %0d want 0", overlap); end
        checks++; if (rdy_data !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data got %h want cafef00d", rdy_data); end
    endtask

    task automatic test_reset_mid;
        slave(1, 1, 0, 0, 0); bresp = 2'b00;
        start(1, 32'h50, 32'h11223344, 4'hF);
        repeat (2) tick();
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL mid_in_wr_resp got bready=%b want 1", bready); end
        reset = 1;
        tick();
        checks++; if ({awvalid, wvalid, arvalid, bready, rready, bus_ready, bus_err} !== 7'b0) begin errors++; $display("FAIL mid_flags got %b want 0000000", {awvalid, wvalid, arvalid, bready, rready, bus_ready, bus_err}); end
        checks++; if ({awaddr, wdata, wstrb, araddr} !== 100'h0) begin errors++; $display("FAIL mid_payload got %h want 0", {awaddr, wdata, wstrb, araddr}); end
        checks++; if (bus_rd_data !== 32'h0) begin errors++; $display("FAIL mid_rd_data got %h want 0", bus_rd_data); end
        reset = 0; bvalid = 1;
        repeat (10) tick();
        checks++; if (n_rdy !== 0) begin errors++; $display("FAIL mid_no_ready got %0d pulses want 0", n_rdy); end
    endtask

    task automatic test_timeout;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
        logic ar_c8 = 0;
        slave(0, 0, 0, 0, 0);
        start(0, 32'h60, 32'h0, 4'h0);
        for (int i = 0; i < 12; i++) begin
            if (cyc == 8) ar_c8 = arvalid;
            tick();
        end
        checks++; if (ar_c8 !== 1'b1) begin errors++; $display("FAIL to_arvalid_c8 got %b want 1", ar_c8); end
        checks++; if (first_rdy !== 9 || n_rdy !== 1) begin errors++; $display("FAIL to_ready got cyc=%0d n=%0d want cyc=9 n=1", first_rdy, n_rdy); end
        checks++; if (rdy_err !== 1'b1 || rdy_data !== 32'h0) begin errors++; $display("FAIL to_result got err=%b data=%h want err=1 data=0", rdy_err, rdy_data); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL to_arvalid_drop got %b want 0", arvalid); end
`else
        slave(0, 0, 0, 0, 0);
        start(0, 32'h60, 32'h0, 4'h0);
        repeat (40) tick();
        checks++; if (n_rdy !== 0) begin errors++; $display("FAIL wait_forever got %0d pulses want 0", n_rdy); end
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL wait_arvalid got %b want 1", arvalid); end
        reset = 1;
        tick();
        reset = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_slverr();
        test_write_late_wready();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
